// File: rtl/otter_mtimer.sv
// -----------------------------------------------------------------------------
// otter_mtimer
//   Memory-mapped machine timer and software-interrupt source for one hart.
//   Holds a 64-bit mtime counter, a 64-bit mtimecmp and an msip bit, and drives
//   MTIP (bit 7) and MSIP (bit 3) of the interrupt vector into the CSR unit.
//
//   Register map (word index = i_bus_addr[4:2]):
//     0 MSIP (bit 0), 1 MTIMECMP_LO, 2 MTIMECMP_HI, 3 MTIME_LO, 4 MTIME_HI,
//     5-7 unmapped (read 0, writes ignored, still acknowledged).
//
//   Optional build macro:
//     OTTER_MTIMER_PRESCALER_EN - mtime advances once every PRESCALE cycles
//                                 instead of every cycle.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_bus_rd     read request pulse
//   i_bus_wr     write request pulse (wins over a simultaneous read)
//   i_bus_addr   byte offset; [4:2] selects the register
//   i_bus_wdata  write data
//   i_bus_wstrb  byte enables for writes
//   o_bus_rdata  read data, non-zero only while o_bus_ack is high
//   o_bus_ack    one-cycle acknowledge, registered, for every request
//   o_intrpt     interrupt vector: [7]=MTIP, [3]=MSIP, others 0
// -----------------------------------------------------------------------------
module otter_mtimer #(
    parameter int PRESCALE = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_rd,
    input  logic        i_bus_wr,
    input  logic [4:0]  i_bus_addr,
    input  logic [31:0] i_bus_wdata,
    input  logic [3:0]  i_bus_wstrb,
    output logic [31:0] o_bus_rdata,
    output logic        o_bus_ack,
    output logic [31:0] o_intrpt
);

    localparam logic [2:0] IDX_MSIP     = 3'd0;
    localparam logic [2:0] IDX_CMP_LO   = 3'd1;
    localparam logic [2:0] IDX_CMP_HI   = 3'd2;
    localparam logic [2:0] IDX_MTIME_LO = 3'd3;
    localparam logic [2:0] IDX_MTIME_HI = 3'd4;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic [31:0] hi_shadow;

    logic        ack_p1;
    logic [31:0] rdata_p1;
    logic        mtip_p1;

    logic [2:0]  idx;
    logic        rd_en;
    logic        wr_mtime;
    logic        tick;
    logic        unused_addr;

    assign idx         = i_bus_addr[4:2];
    assign unused_addr = ^i_bus_addr[1:0];
    // A simultaneous write suppresses the read side entirely.
    assign rd_en       = i_bus_rd & ~i_bus_wr;
    assign wr_mtime    = i_bus_wr & ((idx == IDX_MTIME_LO) | (idx == IDX_MTIME_HI));

`ifdef OTTER_MTIMER_PRESCALER_EN
    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt;

    assign tick = (pcnt == PCNT_LAST);

    // Writing mtime restarts the prescale period so the next increment comes
    // a full PRESCALE cycles after the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)               pcnt <= '0;
        else if (wr_mtime || tick)  pcnt <= '0;
        else                        pcnt <= pcnt + 1'b1;
    end
`else
    assign tick = 1'b1;
`endif

    // ---- stage p1: registered bus response, compare and register updates ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            hi_shadow <= '0;
            ack_p1    <= 1'b0;
            rdata_p1  <= '0;
            mtip_p1   <= 1'b0;
        end else begin
            ack_p1   <= i_bus_rd | i_bus_wr;
            rdata_p1 <= '0;
            mtip_p1  <= (mtime >= mtimecmp);

            // A write to either half of mtime takes priority over the tick;
            // the untouched half keeps its value and no carry is applied.
            if (wr_mtime) begin
                if (idx == IDX_MTIME_LO)
                    mtime[31:0]  <= byte_merge(mtime[31:0], i_bus_wdata, i_bus_wstrb);
                else
                    mtime[63:32] <= byte_merge(mtime[63:32], i_bus_wdata, i_bus_wstrb);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (i_bus_wr) begin
                case (idx)
                    IDX_MSIP:   if (i_bus_wstrb[0]) msip <= i_bus_wdata[0];
                    IDX_CMP_LO: mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], i_bus_wdata, i_bus_wstrb);
                    IDX_CMP_HI: mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], i_bus_wdata, i_bus_wstrb);
                    default: ;
                endcase
            end

            // Reading the low half snapshots the high half so a following
            // read of MTIME_HI is coherent with it.
            if (rd_en) begin
                case (idx)
                    IDX_MSIP:     rdata_p1 <= {31'd0, msip};
                    IDX_CMP_LO:   rdata_p1 <= mtimecmp[31:0];
                    IDX_CMP_HI:   rdata_p1 <= mtimecmp[63:32];
                    IDX_MTIME_LO: begin
                        rdata_p1  <= mtime[31:0];
                        hi_shadow <= mtime[63:32];
                    end
                    IDX_MTIME_HI: rdata_p1 <= hi_shadow;
                    default:      rdata_p1 <= '0;
                endcase
            end
        end
    end

    assign o_bus_ack   = ack_p1;
    assign o_bus_rdata = rdata_p1;
    assign o_intrpt    = {24'd0, mtip_p1, 3'd0, msip, 3'd0};

endmodule
